regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, register 0 reads 0 and is never written or busy when 1.
REQ-004 SHALL provide parameter BYPASS, default 1, same-cycle write-to-read forwarding enabled when 1.
REQ-005 SHALL provide parameter INIT_INDEX, default 1, reset loads register i with value i when 1, else 0.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have ports as follows:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- read_reg_1  in  ADDR_W  read port 1 address
- read_reg_2  in  ADDR_W  read port 2 address
- read_data_1  out  DATA_W  read port 1 data
- read_data_2  out  DATA_W  read port 2 data
- read_busy_1  out  1  register at read_reg_1 has a pending write
- read_busy_2  out  1  register at read_reg_2 has a pending write
- regwrite_a  in  1  write port A enable
- write_reg_a  in  ADDR_W  write port A address
- write_data_a  in  DATA_W  write port A data
- regwrite_b  in  1  write port B enable
- write_reg_b  in  ADDR_W  write port B address
- write_data_b  in  DATA_W  write port B data
- alloc_en  in  1  request to mark alloc_reg busy
- alloc_reg  in  ADDR_W  register to mark busy
- alloc_ready  out  1  allocation accepted this cycle
- busy_count  out  ADDR_W+1  number of registers currently busy

Function
REQ-008 SHALL read combinationally: read_data_n = regfile[read_reg_n], with no clock latency.
REQ-009 SHALL, when BYPASS=1 and a write port is enabled to read_reg_n this cycle, return that write data on read_data_n; if both ports hit, port B data.
REQ-010 SHALL write on the rising edge: regfile[write_reg_a] <= write_data_a if regwrite_a, and likewise for port B.
REQ-011 SHALL, on same-address simultaneous writes, store write_data_b (port B priority).
REQ-012 SHALL, when ZERO_REG=1, ignore writes and allocations to address 0; read_data_n = 0 and read_busy_n = 0 for address 0, bypass included.
REQ-013 SHALL hold one busy bit per register; an enabled write clears the busy bit of its address on the same edge.
REQ-014 SHALL assert alloc_ready = alloc_en AND target not busy; when BYPASS=1, a target being cleared by a write this cycle counts as not busy.
REQ-015 SHALL set busy[alloc_reg] on the edge when alloc_ready=1; a same-cycle write and allocation to one address leave the bit set (allocation wins).
REQ-016 SHALL drive alloc_ready=0 for address 0 when ZERO_REG=1.
REQ-017 SHALL drive read_busy_n = busy[read_reg_n]; when BYPASS=1, it is 0 if a write to read_reg_n is enabled this cycle.
REQ-018 SHALL maintain busy_count as a registered counter: +1 per accepted allocation, -1 per busy bit cleared, net change per edge in {-2..+1}, never wrapping.
REQ-019 SHALL make a write to a non-busy register update data without changing busy_count.

Reset
REQ-020 SHALL, on rising edge with rst=1, load regfile[i] = i (INIT_INDEX=1) or 0, clear all busy bits, set busy_count = 0.
REQ-021 SHALL let reset dominate: writes and allocations presented during rst are discarded.
REQ-022 SHALL drive, after reset, read_data_n = reset contents of read_reg_n, read_busy_n = 0 and alloc_ready = alloc_en (address 0 excepted).

Verification
REQ-023 Reset then read_reg_1=5, read_reg_2=31 -> read_data_1=5, read_data_2=31, busy_count=0.
REQ-024 regwrite_a=1, write_reg_a=3, data 0x14, reading 3, BYPASS=1 -> read_data_1=0x14 same cycle, 0x14 after edge; write to 0 with data 0x55 -> address 0 still reads 0.
REQ-025 Both ports write reg 7 (A=0x1E, B=0x28) -> reg 7 = 0x28.
REQ-026 alloc reg 9 -> busy_count=1, read_busy=1; second alloc of 9 -> alloc_ready=0; write reg 9 with alloc reg 9 same cycle -> busy stays set, count stays 1.
REQ-027 Allocate regs 4 and 6, then write both in one cycle via A and B -> busy_count 2 -> 0, read_busy both 0.
REQ-028 rst=1 asserted while regwrite_a=1 (reg 2, 0x99) and alloc_en=1 -> reg 2 = 2, busy_count = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-read/two-write register file with per-register busy scoreboard and allocation port.
// Reads, bypass and alloc_ready are combinational; state updates on the clock edge; a busy target refuses allocation.
module regfile_sb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter bit INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic              regwrite_a,
  input  logic [ADDR_W-1:0] write_reg_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic              regwrite_b,
  input  logic [ADDR_W-1:0] write_reg_b,
  input  logic [DATA_W-1:0] write_data_b,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic              alloc_ready,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic we_a, we_b;
  logic alloc_hit_wr, dec_a, dec_b, inc;

  // Writes to the hardwired zero register are dropped before they touch anything.
  assign we_a = regwrite_a && !(ZERO_REG && write_reg_a == '0);
  assign we_b = regwrite_b && !(ZERO_REG && write_reg_b == '0);

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] ra,
                                                input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] d;
    d = stored;
    if (BYPASS && we_a && write_reg_a == ra) d = write_data_a;
    if (BYPASS && we_b && write_reg_b == ra) d = write_data_b;
    if (ZERO_REG && ra == '0) d = '0;
    return d;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] ra, input logic stored);
    logic b;
    b = stored;
    if (BYPASS && ((we_a && write_reg_a == ra) || (we_b && write_reg_b == ra))) b = 1'b0;
    if (ZERO_REG && ra == '0) b = 1'b0;
    return b;
  endfunction

  assign read_data_1 = rd_data(read_reg_1, regs[read_reg_1]);
  assign read_data_2 = rd_data(read_reg_2, regs[read_reg_2]);
  assign read_busy_1 = rd_busy(read_reg_1, busy[read_reg_1]);
  assign read_busy_2 = rd_busy(read_reg_2, busy[read_reg_2]);

  assign alloc_hit_wr = (we_a && write_reg_a == alloc_reg) || (we_b && write_reg_b == alloc_reg);
  assign alloc_ready  = alloc_en && !(ZERO_REG && alloc_reg == '0) &&
                        !(busy[alloc_reg] && !(BYPASS && alloc_hit_wr));

  // Count transitions of busy bits: a write/alloc collision leaves the bit set, so no change.
  assign inc   = alloc_ready && !busy[alloc_reg];
  assign dec_a = we_a && busy[write_reg_a] && !(alloc_ready && alloc_reg == write_reg_a);
  assign dec_b = we_b && busy[write_reg_b] && !(we_a && write_reg_a == write_reg_b) &&
                 !(alloc_ready && alloc_reg == write_reg_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= INIT_INDEX ? DATA_W'(i) : '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (we_a) regs[write_reg_a] <= write_data_a;
      if (we_b) regs[write_reg_b] <= write_data_b;
      for (int i = 0; i < DEPTH; i++) begin
        if ((we_a && write_reg_a == ADDR_W'(i)) || (we_b && write_reg_b == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
        if (alloc_ready && alloc_reg == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end
      end
      busy_count <= busy_count + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec_a) - (ADDR_W + 1)'(dec_b);
    end
  end

endmodule
